// File: rtl/data_memory_mc.sv
// Multi-cycle byte/half/word data memory for the MIPS MEM stage: req/ready/done
// handshake, programmable wait states, lane write enables and extended loads.
module data_memory_mc #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] read_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  r_done, r_err, w_done_nxt, w_err_nxt;
  logic [31:0]           r_read_data;
  logic                  r_we, r_uns;
  logic [1:0]            r_size, r_lane;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

  logic                  w_accept, w_bad;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_lanes, w_rd_word;
  logic                  w_unused_addr;

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the right-justified data puts it in every lane; the mask picks one.
  function automatic logic [31:0] place_store(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (sz)
      2'b00:   return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  assign w_accept      = (r_state == S_IDLE) && req;
  assign w_bad         = (size == 2'b11) || (size == 2'b01 && address[0]) ||
                         (size == 2'b10 && address[1:0] != 2'b00);
  assign w_be          = lane_mask(r_size, r_lane);
  assign w_wdata_lanes = place_store(r_size, r_wdata);
  assign w_rd_word     = r_mem[r_idx];
  assign w_unused_addr = ^address[31:ADDR_WIDTH+2];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_bad) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end else if (WS == 4'd0) begin
            w_state_nxt = S_ACCESS;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_read_data <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (r_state == S_ACCESS && !r_we)
        r_read_data <= load_extract(w_rd_word, r_size, r_lane, r_uns);
    end
  end

  // Transaction fields are captured on the accepting edge so the core may move on.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= we;
      r_uns   <= unsigned_ld;
      r_size  <= size;
      r_lane  <= address[1:0];
      r_idx   <= address[ADDR_WIDTH+1:2];
      r_wdata <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_we) begin
      if (w_be[0]) r_mem[r_idx][7:0]   <= w_wdata_lanes[7:0];
      if (w_be[1]) r_mem[r_idx][15:8]  <= w_wdata_lanes[15:8];
      if (w_be[2]) r_mem[r_idx][23:16] <= w_wdata_lanes[23:16];
      if (w_be[3]) r_mem[r_idx][31:24] <= w_wdata_lanes[31:24];
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign read_data = r_read_data;

endmodule
